// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file dump transmitter.
// Covers the FSM state encoding, dump geometry and the default header byte.
package regdump_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } state_t;

    localparam int NUM_REGS       = 32;
    localparam int BYTES_PER_DUMP = 130;
    localparam int FRAME_BITS     = 10;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready handshake.
// ready rises in the last cycle of the stop bit so consecutive frames abut with no idle gap.
module uart_tx_byte
    import regdump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int              TW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]   T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      B_LAST = 4'(FRAME_BITS - 1);

    logic          active;
    logic [TW-1:0] timer;
    logic [3:0]    bit_idx;
    logic [7:0]    shreg;

    assign ready = !active || (bit_idx == B_LAST && timer == T_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            timer   <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else if (valid && ready) begin
            active  <= 1'b1;
            timer   <= '0;
            bit_idx <= '0;
            tx      <= 1'b0;
        end else if (active) begin
            if (timer == T_LAST) begin
                timer <= '0;
                if (bit_idx == B_LAST) begin
                    active <= 1'b0;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    // Moving into bit i+1: data bits for 1..8, stop bit for 9.
                    tx      <= (bit_idx == 4'd8) ? 1'b1 : shreg[bit_idx[2:0]];
                end
            end else begin
                timer <= timer + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (valid && ready) begin
            shreg <= data;
        end
    end

endmodule

// File: rtl/regfile_dump_tx.sv
// Captures the 32-entry register snapshot on start and streams it as UART frames:
// header, 128 little-endian data bytes (x0 first), then the XOR of the data bytes.
module regfile_dump_tx
    import regdump_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] HEADER       = DEFAULT_HEADER
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_REGS*32-1:0] regs_flat,
    output logic                   uart_tx,
    output logic                   busy,
    output logic                   done
);

    localparam logic [7:0] IDX_CSUM = 8'(BYTES_PER_DUMP - 1);
    localparam logic [7:0] IDX_END  = 8'(BYTES_PER_DUMP);

    state_t                 state;
    logic [NUM_REGS*32-1:0] snapshot;
    logic [7:0]             byte_idx;
    logic [7:0]             checksum;
    logic [7:0]             tx_data;
    logic [6:0]             data_k;
    logic                   tx_valid;
    logic                   tx_ready;
    logic                   hs;

    always_comb begin
        data_k   = 7'(byte_idx - 8'd1);
        tx_data  = HEADER;
        if (byte_idx == IDX_CSUM) begin
            tx_data = checksum;
        end else if (byte_idx != 8'd0) begin
            tx_data = snapshot[{data_k, 3'b000} +: 8];
        end
        // The header is handed over during LOAD so its start bit lands two cycles after start.
        tx_valid = (state == LOAD) || (state == SEND && byte_idx < IDX_END);
    end

    assign hs = tx_valid && tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            byte_idx <= '0;
            checksum <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        byte_idx <= '0;
                        checksum <= '0;
                    end
                end
                LOAD: begin
                    state <= SEND;
                    if (hs) begin
                        byte_idx <= byte_idx + 8'd1;
                    end
                end
                SEND: begin
                    if (hs) begin
                        byte_idx <= byte_idx + 8'd1;
                        if (byte_idx < IDX_CSUM) begin
                            checksum <= checksum ^ tx_data;
                        end
                    end else if (byte_idx == IDX_END && tx_ready) begin
                        // Serializer is in its final stop-bit cycle with nothing left to send.
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            snapshot <= regs_flat;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk  (clk),
        .rst_n(rst_n),
        .data (tx_data),
        .valid(tx_valid),
        .ready(tx_ready),
        .tx   (uart_tx)
    );

endmodule
